// File: rtl/ahb_s2m_dpmux.sv
// ahb_s2m_dpmux: AHB slave-to-master response multiplexer with default-slave ERROR handling.
//
// The decoder's address-phase hsel is captured into a data-phase select whenever HREADY is
// high. The selected slave's HREADYOUT/HRESP/HEXOKAY/HRDATA then reach the master with no
// added latency. If no slave (or more than one slave) is selected for an active transfer,
// the block answers with the two-cycle AHB ERROR response itself.
//
// Optional feature (macro AHB_S2M_TIMEOUT_EN): a wait-state counter. When a selected slave
// stalls an active transfer for TIMEOUT_CYCLES cycles, hto_o pulses and the block takes over
// the data phase with an ERROR response.
//
// Ports:
//   hclk        clock; all state changes on its rising edge
//   hrst        synchronous active-high reset
//   hsel        address-phase one-hot slave select (HSLV_NUM bits)
//   htrans      address-phase transfer type
//   hready_i    per-slave HREADYOUT
//   hresp_i     per-slave HRESP
//   hexokay_i   per-slave HEXOKAY
//   hrdata_i    per-slave HRDATA, slave k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   hready_o    muxed HREADY to the master and back to all slaves
//   hresp_o     muxed HRESP
//   hexokay_o   muxed HEXOKAY
//   hrdata_o    muxed HRDATA
//   hto_o       one-cycle pulse when a timeout ERROR is launched
module ahb_s2m_dpmux #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned HSLV_NUM       = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                           hclk,
    input  logic                           hrst,
    input  logic [HSLV_NUM-1:0]            hsel,
    input  logic [1:0]                     htrans,
    input  logic [HSLV_NUM-1:0]            hready_i,
    input  logic [HSLV_NUM-1:0]            hresp_i,
    input  logic [HSLV_NUM-1:0]            hexokay_i,
    input  logic [HSLV_NUM*DATA_WIDTH-1:0] hrdata_i,
    output logic                           hready_o,
    output logic                           hresp_o,
    output logic                           hexokay_o,
    output logic [DATA_WIDTH-1:0]          hrdata_o,
    output logic                           hto_o
);

    localparam int unsigned IdxW = (HSLV_NUM > 1) ? $clog2(HSLV_NUM) : 1;

    typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

    // Data-phase select: DEFAULT is encoded as dsel_hit_q = 0.
    logic            dsel_hit_q, dsel_hit_d;
    logic [IdxW-1:0] dsel_idx_q, dsel_idx_d;
    logic            active_q, active_d;
    state_e          state_q, state_d;

    logic            dec_hit;
    logic [IdxW-1:0] dec_idx;
    logic            slv_waiting;
    logic            timeout;

    // Address-phase decode: a hit only when exactly one hsel bit is set.
    always_comb begin
        dec_idx = '0;
        for (int i = 0; i < int'(HSLV_NUM); i++) begin
            if (hsel[i]) dec_idx = IdxW'(i);
        end
        dec_hit = (hsel != '0) && ((hsel & (hsel - HSLV_NUM'(1))) == '0);
    end

    // Selected slave is stretching an active transfer that we have not taken over.
    assign slv_waiting = (state_q == StIdle) && dsel_hit_q && active_q && !hready_i[dsel_idx_q];

`ifdef AHB_S2M_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Fires during the TIMEOUT_CYCLES-th wait cycle; the next edge enters ERR1.
    assign timeout = slv_waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (timeout || hready_o) begin
            cnt_d = '0;
        end else if (slv_waiting) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge hclk) begin
        if (hrst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign hto_o = timeout;

    // Response mux; the ERROR states override whatever dsel points at.
    always_comb begin
        hready_o  = 1'b1;
        hresp_o   = 1'b0;
        hexokay_o = 1'b0;
        hrdata_o  = '0;
        case (state_q)
            StErr1: begin
                hready_o = 1'b0;
                hresp_o  = 1'b1;
            end
            StErr2: begin
                hready_o = 1'b1;
                hresp_o  = 1'b1;
            end
            default: begin
                if (dsel_hit_q) begin
                    hready_o  = hready_i[dsel_idx_q];
                    hresp_o   = hresp_i[dsel_idx_q];
                    hexokay_o = hexokay_i[dsel_idx_q];
                    hrdata_o  = hrdata_i[int'(dsel_idx_q) * DATA_WIDTH +: DATA_WIDTH];
                end
            end
        endcase
    end

    // Next state: timeout wins, else a completed data phase reloads from the address phase.
    always_comb begin
        state_d    = state_q;
        dsel_hit_d = dsel_hit_q;
        dsel_idx_d = dsel_idx_q;
        active_d   = active_q;
        if (timeout) begin
            state_d = StErr1;
        end else if (hready_o) begin
            dsel_hit_d = dec_hit;
            dsel_idx_d = dec_idx;
            active_d   = htrans[1];
            state_d    = (!dec_hit && htrans[1]) ? StErr1 : StIdle;
        end else if (state_q == StErr1) begin
            state_d = StErr2;
        end
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q    <= StIdle;
            dsel_hit_q <= 1'b0;
            dsel_idx_q <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dsel_hit_q <= dsel_hit_d;
            dsel_idx_q <= dsel_idx_d;
            active_q   <= active_d;
        end
    end

endmodule

// File: doc/ahb_s2m_dpmux.md
AHB_S2M_DPMUX -- requirements
Module: ahb_s2m_dpmux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the HRDATA width.
REQ-002 SHALL have parameter HSLV_NUM, default 5, the number of slave ports (range 1..32).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the wait-state limit used by the timeout feature (range 2..1023).
REQ-004 SHALL have port hclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port hrst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port hsel, input, HSLV_NUM bits: address-phase one-hot slave select from the decoder.
REQ-007 SHALL have port htrans, input, 2 bits: address-phase transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 SHALL have port hready_i, input, HSLV_NUM x 1 bit: per-slave HREADYOUT.
REQ-009 SHALL have port hresp_i, input, HSLV_NUM x 1 bit: per-slave HRESP.
REQ-010 SHALL have port hexokay_i, input, HSLV_NUM x 1 bit: per-slave HEXOKAY.
REQ-011 SHALL have port hrdata_i, input, HSLV_NUM x DATA_WIDTH bits: per-slave HRDATA.
REQ-012 SHALL have port hready_o, output, 1 bit: muxed HREADY to the master and fed back to all slaves.
REQ-013 SHALL have port hresp_o, output, 1 bit: muxed HRESP.
REQ-014 SHALL have port hexokay_o, output, 1 bit: muxed HEXOKAY.
REQ-015 SHALL have port hrdata_o, output, DATA_WIDTH bits: muxed HRDATA.
REQ-016 SHALL have port hto_o, output, 1 bit: one-cycle pulse when a timeout error is launched.

Function
REQ-017 Data-phase select register (dsel) SHALL load the address-phase decode on every hclk edge where hready_o=1, and hold its value otherwise.
REQ-018 Decode result SHALL be: slave k if hsel is one-hot at bit k; DEFAULT otherwise (zero-hot or multi-hot).
REQ-019 A transfer SHALL be "active" when htrans[1]=1; the active flag SHALL be registered alongside dsel.
REQ-020 With dsel=k, the outputs SHALL combinationally equal hready_i[k], hresp_i[k], hexokay_i[k] and hrdata_i[k], adding zero latency.
REQ-021 With dsel=DEFAULT and the transfer not active (IDLE or BUSY), outputs SHALL be hready_o=1, hresp_o=0, hexokay_o=0 and hrdata_o=0.
REQ-022 With dsel=DEFAULT and the transfer active, the block SHALL run the ERROR FSM ERR1 -> ERR2 -> IDLE.
REQ-023 In ERR1, outputs SHALL be hready_o=0 and hresp_o=1; in ERR2, hready_o=1 and hresp_o=1. In both states, hexokay_o=0 and hrdata_o=0.
REQ-024 During ERR2 (hready_o=1), the next address phase SHALL be sampled per REQ-017, so back-to-back transfers are supported.
REQ-025 When dsel changes, outputs SHALL switch in the same cycle the new data phase begins, with no bubble cycle.

Reset
REQ-026 While hrst=1 at a clock edge, dsel SHALL become DEFAULT, the active flag 0, the FSM IDLE, the timeout counter 0 and hto_o 0.
REQ-027 After reset, outputs SHALL be hready_o=1, hresp_o=0, hexokay_o=0 and hrdata_o=0.
REQ-028 Reset asserted mid-ERR1, mid-ERR2 or mid-wait SHALL abandon the sequence and take effect on the same edge.

Configuration
REQ-029 When macro AHB_S2M_TIMEOUT_EN is defined, a counter SHALL increment each cycle that dsel=k, the transfer is active and hready_i[k]=0; the counter SHALL clear whenever hready_o=1.
REQ-030 With AHB_S2M_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL pulse hto_o for 1 cycle and enter ERR1. For that data phase it SHALL then ignore slave k (outputs per REQ-023), and dsel SHALL then reload normally on the ERR2 edge.
REQ-031 When AHB_S2M_TIMEOUT_EN is undefined, no counter SHALL exist, hto_o SHALL be tied to 0, and slave wait states SHALL pass through unbounded.

Verification
REQ-032 Bench SHALL cover: hsel=00100 with NONSEQ, slave 2 ready with hrdata=0xA5A5_0001 -> next cycle hrdata_o=0xA5A5_0001, hready_o=1, hresp_o=0.
REQ-033 Bench SHALL cover: hsel=00000 with NONSEQ -> hready_o/hresp_o = 0/1, then 1/1, then a new transfer is accepted.
REQ-034 Bench SHALL cover: hsel=00011 with SEQ -> two-cycle ERROR identical to REQ-033; with IDLE instead -> hready_o=1, hresp_o=0.
REQ-035 Bench SHALL cover: slave 1 holds hready_i low for 3 cycles while the address phase shows hsel=10000 -> dsel stays at 1 for 3 cycles, then moves to 4 on the ready edge.
REQ-036 Bench SHALL cover (AHB_S2M_TIMEOUT_EN defined, TIMEOUT_CYCLES=4): slave 0 never ready -> hto_o pulses on wait cycle 4, followed by ERR1/ERR2. With the macro undefined, hready_o stays 0 and hto_o stays 0.
REQ-037 Bench SHALL cover: hrst pulsed during ERR1 -> the next cycle shows hready_o=1, hresp_o=0 and dsel=DEFAULT.
